// File: rtl/manchester_decoder.sv
// Manchester line receiver: half-bit phase hunt, sync-byte alignment, byte output.
// Define MANCHESTER_DEC_SYNC2_EN to pass line_in through a two-flop synchronizer first.
module manchester_decoder #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned LOCK_PAIRS     = 4,
    parameter int unsigned SEARCH_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_in,
    input  logic       decode_mode,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic       code_err
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SEARCH,
        ST_LOCKED
    } state_e;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_PAIRS);
    localparam logic [8:0] TMO_LIM  = 9'(SEARCH_TIMEOUT);

    state_e     state_q, state_d;
    logic       phase_q, phase_d;
    logic       first_q, first_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] pair_cnt_q, pair_cnt_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;

    logic       line_s;
    logic       pair_ok;
    logic       dec_bit;
    logic       slip;
    logic [7:0] shifted;
    logic [8:0] tmo_next;
    logic [3:0] pair_next;

`ifdef MANCHESTER_DEC_SYNC2_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
        end
    end

    assign line_s = sync2_q;
`else
    assign line_s = line_in;
`endif

    assign pair_ok   = first_q ^ line_s;
    assign dec_bit   = first_q ^ decode_mode;
    assign shifted   = {dec_bit, shift_q[7:1]};
    assign tmo_next  = {1'b0, tmo_cnt_q} + 9'd1;
    assign pair_next = (pair_cnt_q == 4'hF) ? pair_cnt_q : pair_cnt_q + 4'd1;

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        first_d    = first_q;
        shift_d    = shift_q;
        pair_cnt_d = pair_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        slip       = 1'b0;

        if (!phase_q) begin
            first_d = line_s;
            phase_d = 1'b1;
        end else begin
            phase_d = 1'b0;
            unique case (state_q)
                ST_HUNT: begin
                    if (pair_ok) begin
                        pair_cnt_d = pair_next;
                        if (pair_next >= LOCK_LIM) begin
                            state_d    = ST_SEARCH;
                            tmo_cnt_d  = 8'd0;
                            pair_cnt_d = 4'd0;
                        end
                    end else begin
                        slip = 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (pair_ok) begin
                        shift_d   = shifted;
                        tmo_cnt_d = tmo_next[7:0];
                        // A match wins over a timeout reached on the same pair.
                        if (shifted == SYNC_BYTE) begin
                            state_d   = ST_LOCKED;
                            bit_cnt_d = 3'd0;
                        end else if (tmo_next >= TMO_LIM) begin
                            slip = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                        slip  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (pair_ok) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = shifted;
                            valid_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                        slip  = 1'b1;
                    end
                end
                default: slip = 1'b1;
            endcase

            // Slip: the current half becomes the new first half, moving the pair boundary by one clock.
            if (slip) begin
                state_d    = ST_HUNT;
                pair_cnt_d = 4'd0;
                first_d    = line_s;
                phase_d    = 1'b1;
            end
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            shift_q    <= 8'd0;
            pair_cnt_q <= 4'd0;
            tmo_cnt_q  <= 8'd0;
            bit_cnt_q  <= 3'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            shift_q    <= shift_d;
            pair_cnt_q <= pair_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign locked     = locked_q;
    assign code_err   = err_q;

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed bench for manchester_decoder: bench-side Manchester encoder, behavioural
// receiver model compared every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_manchester_decoder;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int LOCK_PAIRS = 4;
    localparam int TMO        = 64;
`ifdef MANCHESTER_DEC_SYNC2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_in = 1'b0;
    logic       decode_mode = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       code_err;

    manchester_decoder #(
        .SYNC_BYTE      (SYNC),
        .LOCK_PAIRS     (LOCK_PAIRS),
        .SEARCH_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_in     (line_in),
        .decode_mode (decode_mode),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .locked      (locked),
        .code_err    (code_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural receiver model ----------------
    localparam int M_HUNT = 0, M_SEARCH = 1, M_LOCKED = 2;
    int         m_mode;
    bit         m_have;
    bit         m_first;
    bit         m_bits[$];
    int         m_pairs, m_tries, m_nbits, m_timeouts;
    logic [7:0] m_dout;
    bit         m_dv, m_lock, m_err;
    bit         m_p0, m_p1;

    function automatic logic [7:0] m_byte();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_bits[i];
        return v;
    endfunction

    function automatic void model_step(input logic rst, input logic raw, input logic dm);
        bit line, good, b, slip;
        if (!rst) begin
            m_mode = M_HUNT; m_have = 0; m_first = 0;
            m_bits.delete();
            for (int i = 0; i < 8; i++) m_bits.push_back(1'b0);
            m_pairs = 0; m_tries = 0; m_nbits = 0;
            m_dout = 8'd0; m_dv = 0; m_lock = 0; m_err = 0;
            m_p0 = 0; m_p1 = 0;
            return;
        end
`ifdef MANCHESTER_DEC_SYNC2_EN
        line = m_p1; m_p1 = m_p0; m_p0 = raw;
`else
        line = raw;
`endif
        m_dv = 0; m_err = 0;
        if (!m_have) begin
            m_first = line;
            m_have  = 1;
        end else begin
            good = (m_first != line);
            b    = m_first ^ dm;
            slip = 0;
            m_have = 0;
            if (m_mode == M_HUNT) begin
                if (good) begin
                    if (m_pairs < 15) m_pairs++;
                    if (m_pairs >= LOCK_PAIRS) begin
                        m_mode = M_SEARCH; m_tries = 0; m_pairs = 0;
                    end
                end else slip = 1;
            end else if (!good) begin
                m_err = 1; slip = 1;
            end else begin
                m_bits.push_back(b);
                void'(m_bits.pop_front());
                if (m_mode == M_SEARCH) begin
                    m_tries++;
                    if (m_byte() == SYNC) begin
                        m_mode = M_LOCKED; m_nbits = 0;
                    end else if (m_tries >= TMO) begin
                        slip = 1; m_timeouts++;
                    end
                end else begin
                    m_nbits++;
                    if (m_nbits == 8) begin
                        m_nbits = 0; m_dout = m_byte(); m_dv = 1;
                    end
                end
            end
            if (slip) begin
                m_mode = M_HUNT; m_pairs = 0; m_first = line; m_have = 1;
            end
        end
        m_lock = (m_mode == M_LOCKED);
    endfunction

    int cyc = 0;
    always @(posedge clk) begin
        cyc++;
        model_step(rst_n, line_in, decode_mode);
    end

    // ---------------- compare process and event log ----------------
    logic [7:0] vdata[$];
    int         vcyc[$];
    int         err_cnt = 0;
    int         lock_cyc = -1;
    int         rel_cyc = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("cmp_data_out", 32'(data_out), 32'(m_dout));
            check("cmp_data_valid", 32'(data_valid), 32'(m_dv));
            check("cmp_locked", 32'(locked), 32'(m_lock));
            check("cmp_code_err", 32'(code_err), 32'(m_err));
            if (data_valid === 1'b1) begin
                vdata.push_back(data_out);
                vcyc.push_back(cyc);
            end
            if (code_err === 1'b1) begin
                err_cnt++;
                check("no_valid_on_err", 32'(data_valid), 32'd0);
            end
            if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic half(input logic v, input logic r);
        @(posedge clk);
        #1;
        line_in = v;
        rst_n   = r;
    endtask

    // Encoder: mode 0 sends (bit, ~bit), mode 1 sends (~bit, bit), LSB first.
    task automatic send_byte(input logic [7:0] b, input logic enc_mode, input int bad_bit, input int rst_bit);
        for (int i = 0; i < 8; i++) begin
            logic h1;
            h1 = b[i] ^ enc_mode;
            half((i == bad_bit) ? 1'b1 : h1, (i == rst_bit) ? 1'b0 : 1'b1);
            half((i == bad_bit) ? 1'b1 : ~h1, 1'b1);
            if (i == rst_bit) begin
                check("rst_data_out", 32'(data_out), 32'd0);
                check("rst_data_valid", 32'(data_valid), 32'd0);
                check("rst_locked", 32'(locked), 32'd0);
                check("rst_code_err", 32'(code_err), 32'd0);
            end
        end
    endtask

    task automatic start_test(input logic dm);
        rst_n = 1'b0;
        decode_mode = dm;
        line_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vdata.delete();
        vcyc.delete();
        err_cnt = 0;
        lock_cyc = -1;
        m_timeouts = 0;
        rel_cyc = cyc;
        half(1'b0, 1'b1);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp, input int after, input int min_n);
        int n;
        int prev;
        n = 0;
        prev = -1;
        for (int i = 0; i < vdata.size(); i++) begin
            if (vcyc[i] > after) begin
                check({tag, "_byte"}, 32'(vdata[i]), 32'(exp));
                if (prev >= 0) check({tag, "_gap"}, 32'(vcyc[i] - prev), 32'd16);
                prev = vcyc[i];
                n++;
            end
        end
        check({tag, "_count"}, 32'(n >= min_n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sw;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_code_err", 32'(code_err), 32'd0);

        // Loopback, standard mode.
        start_test(1'b0);
        repeat (8) send_byte(8'hA5, 1'b0, -1, -1);
        check("m0_lock_time", 32'(lock_cyc >= 0 && lock_cyc - rel_cyc <= 64 + LAT), 32'd1);
        check_bytes("m0", 8'hA5, rel_cyc, 4);
        check("m0_no_code_err", 32'(err_cnt), 32'd0);
        check("m0_model_locked", 32'(m_lock), 32'd1);

        // Loopback, inverse mode.
        start_test(1'b1);
        repeat (8) send_byte(8'hA5, 1'b1, -1, -1);
        check("m1_lock_time", 32'(lock_cyc >= 0 && lock_cyc - rel_cyc <= 64 + LAT), 32'd1);
        check_bytes("m1", 8'hA5, rel_cyc, 4);
        check("m1_no_code_err", 32'(err_cnt), 32'd0);

        // Payload after sync, switched at a byte boundary.
        start_test(1'b0);
        repeat (4) send_byte(8'hA5, 1'b0, -1, -1);
        sw = cyc;
        repeat (4) send_byte(8'h3C, 1'b0, -1, -1);
        check_bytes("payload", 8'h3C, sw + 1 + LAT, 3);
        for (int i = 0; i < vcyc.size(); i++) begin
            if (vcyc[i] > sw + 1 + LAT) begin
                check("payload_first_cycle", 32'(vcyc[i]), 32'(sw + 17 + LAT));
                break;
            end
        end
        check("payload_no_code_err", 32'(err_cnt), 32'd0);

        // Code violation while locked, then relock.
        start_test(1'b0);
        repeat (4) send_byte(8'hA5, 1'b0, -1, -1);
        check("viol_locked_before", 32'(locked), 32'd1);
        send_byte(8'hA5, 1'b0, 3, -1);
        check("viol_err_once", 32'(err_cnt), 32'd1);
        check("viol_unlocked", 32'(locked), 32'd0);
        lock_cyc = -1;
        repeat (6) send_byte(8'hA5, 1'b0, -1, -1);
        check("viol_relocked", 32'(locked), 32'd1);
        check("viol_err_total", 32'(err_cnt), 32'd1);
        check_bytes("viol_after", 8'hA5, lock_cyc, 2);

        // Search timeout on an all-zero stream.
        start_test(1'b0);
        repeat (12) send_byte(8'h00, 1'b0, -1, -1);
        check("tmo_never_locked", 32'(lock_cyc), 32'hFFFF_FFFF);
        check("tmo_no_valid", 32'(vdata.size()), 32'd0);
        check("tmo_no_code_err", 32'(err_cnt), 32'd0);
        check("tmo_model_slipped", 32'(m_timeouts >= 1), 32'd1);

        // Reset pulse four bits into a byte while locked.
        start_test(1'b0);
        repeat (4) send_byte(8'hA5, 1'b0, -1, -1);
        check("rstmid_locked_before", 32'(locked), 32'd1);
        send_byte(8'hA5, 1'b0, -1, 4);
        lock_cyc = -1;
        repeat (6) send_byte(8'hA5, 1'b0, -1, -1);
        check("rstmid_relocked", 32'(locked), 32'd1);
        check_bytes("rstmid_after", 8'hA5, lock_cyc, 2);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
